// File: rtl/enc_pkg.sv
// Shared constants and state encoding for the serial 8:3 index encoder.
package enc_pkg;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/pri_enc8_3.sv
// Combinational priority encoder: index of the highest set bit, 0 when none set.
module pri_enc8_3
  import enc_pkg::*;
(
  input  logic [N-1:0] v,
  output logic [W-1:0] y,
  output logic         any
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) y = W'(i);
    end
  end

  assign any = |v;

endmodule

// File: rtl/enc8_3_serial.sv
// Serial 8:3 encoder: accepts a request vector and emits the index of each set bit,
// highest first, one per output handshake.
module enc8_3_serial
  import enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] idx,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic         done,
  output logic         zero_err
);

  state_e         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [W-1:0]   idx_q, idx_d;

  logic [N-1:0]   nxt;
  logic [W-1:0]   req_idx, nxt_idx;
  logic           req_any, nxt_any;
  logic           in_hs, out_hs;
  logic           done_c, zero_err_c;

  assign req_ready = en & (state_q == IDLE);
  assign idx_valid = (state_q == EMIT);
  assign idx       = idx_q;

  assign in_hs  = req_valid & req_ready;
  assign out_hs = idx_valid & idx_ready & en;

  // Remaining bits once the current index has been consumed.
  assign nxt = pend_q & ~(N'(1) << idx_q);

  pri_enc8_3 u_pri_req (
    .v   (req),
    .y   (req_idx),
    .any (req_any)
  );

  pri_enc8_3 u_pri_nxt (
    .v   (nxt),
    .y   (nxt_idx),
    .any (nxt_any)
  );

  // Next-state, pending mask and pulse generation.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    done_c     = 1'b0;
    zero_err_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          if (req_any) begin
            pend_d  = req;
            idx_d   = req_idx;
            state_d = EMIT;
          end else begin
            zero_err_c = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_hs) begin
          if (nxt_any) begin
            pend_d = nxt;
            idx_d  = nxt_idx;
          end else begin
            pend_d  = '0;
            state_d = IDLE;
            done_c  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over any handshake in the same cycle, so pulses are suppressed.
  assign done     = done_c & ~rst;
  assign zero_err = zero_err_c & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_enc8_3_serial.sv
// Directed bench for enc8_3_serial with hand-computed expected values.
module tb_enc8_3_serial;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] idx;
  logic       idx_valid;
  logic       idx_ready;
  logic       done;
  logic       zero_err;

  int n_cmp;
  int n_err;
  int n_hs;
  int n_done;

  enc8_3_serial dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .done      (done),
    .zero_err  (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_hs = 0; n_done = 0;
    rst = 1'b1; en = 1'b1; req = 8'h00; req_valid = 1'b0; idx_ready = 1'b0;
    tick; tick;
    #1;
    chk("rst_idx_valid", 8'(idx_valid), 8'd0);
    chk("rst_idx", 8'(idx), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_zero_err", 8'(zero_err), 8'd0);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 8'(req_ready), 8'd1);

    // 1: 8'hA4 -> 7,5,2
    req = 8'hA4; req_valid = 1'b1; idx_ready = 1'b1;
    #1;
    chk("t1_req_ready", 8'(req_ready), 8'd1);
    tick;
    req_valid = 1'b0;
    #1;
    chk("t1_valid0", 8'(idx_valid), 8'd1);
    chk("t1_idx0", 8'(idx), 8'd7);
    chk("t1_done0", 8'(done), 8'd0);
    tick; #1;
    chk("t1_idx1", 8'(idx), 8'd5);
    chk("t1_done1", 8'(done), 8'd0);
    tick; #1;
    chk("t1_idx2", 8'(idx), 8'd2);
    chk("t1_done2", 8'(done), 8'd1);
    tick; #1;
    chk("t1_end_valid", 8'(idx_valid), 8'd0);
    chk("t1_end_ready", 8'(req_ready), 8'd1);
    chk("t1_end_done", 8'(done), 8'd0);

    // 2: all-zero vector
    req = 8'h00; req_valid = 1'b1;
    #1;
    chk("t2_zero_err", 8'(zero_err), 8'd1);
    chk("t2_ready", 8'(req_ready), 8'd1);
    tick;
    req_valid = 1'b0;
    #1;
    chk("t2_zero_err_off", 8'(zero_err), 8'd0);
    chk("t2_valid", 8'(idx_valid), 8'd0);
    chk("t2_ready_after", 8'(req_ready), 8'd1);

    // 3: 8'hFF with idx_ready toggling
    req = 8'hFF; req_valid = 1'b1; idx_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    for (int e = 7; e >= 0; e--) begin
      idx_ready = 1'b0;
      #1;
      chk("t3_hold_idx", 8'(idx), 8'(e));
      chk("t3_hold_valid", 8'(idx_valid), 8'd1);
      chk("t3_hold_done", 8'(done), 8'd0);
      tick;
      idx_ready = 1'b1;
      #1;
      chk("t3_hs_idx", 8'(idx), 8'(e));
      chk("t3_hs_done", 8'(done), (e == 0) ? 8'd1 : 8'd0);
      if (idx_valid && idx_ready) n_hs++;
      if (done) n_done++;
      tick;
    end
    #1;
    chk("t3_handshakes", 8'(n_hs), 8'd8);
    chk("t3_done_count", 8'(n_done), 8'd1);
    chk("t3_end_valid", 8'(idx_valid), 8'd0);

    // 4: 8'h81 with en dropped after the first handshake
    req = 8'h81; req_valid = 1'b1; idx_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    #1;
    chk("t4_idx7", 8'(idx), 8'd7);
    chk("t4_done7", 8'(done), 8'd0);
    tick;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_frz_idx", 8'(idx), 8'd0);
      chk("t4_frz_valid", 8'(idx_valid), 8'd1);
      chk("t4_frz_done", 8'(done), 8'd0);
      chk("t4_frz_ready", 8'(req_ready), 8'd0);
      tick;
    end
    en = 1'b1;
    #1;
    chk("t4_last_idx", 8'(idx), 8'd0);
    chk("t4_last_done", 8'(done), 8'd1);
    tick; #1;
    chk("t4_end_valid", 8'(idx_valid), 8'd0);
    chk("t4_end_ready", 8'(req_ready), 8'd1);

    // 5: reset in the middle of 8'h3C
    req = 8'h3C; req_valid = 1'b1; idx_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    #1;
    chk("t5_idx5", 8'(idx), 8'd5);
    tick;
    rst = 1'b1;
    #1;
    chk("t5_rst_done", 8'(done), 8'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("t5_post_valid", 8'(idx_valid), 8'd0);
    chk("t5_post_idx", 8'(idx), 8'd0);
    chk("t5_post_ready", 8'(req_ready), 8'd1);
    chk("t5_post_done", 8'(done), 8'd0);
    req = 8'h01; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    #1;
    chk("t5_new_idx", 8'(idx), 8'd0);
    chk("t5_new_valid", 8'(idx_valid), 8'd1);
    chk("t5_new_done", 8'(done), 8'd1);
    tick; #1;
    chk("t5_end_valid", 8'(idx_valid), 8'd0);

    // 6: next request held during EMIT of 8'h06
    req = 8'h06; req_valid = 1'b1; idx_ready = 1'b1;
    tick;
    req = 8'h10;
    #1;
    chk("t6_idx2", 8'(idx), 8'd2);
    chk("t6_ready_emit0", 8'(req_ready), 8'd0);
    tick; #1;
    chk("t6_idx1", 8'(idx), 8'd1);
    chk("t6_done1", 8'(done), 8'd1);
    chk("t6_ready_emit1", 8'(req_ready), 8'd0);
    tick; #1;
    chk("t6_idle_valid", 8'(idx_valid), 8'd0);
    chk("t6_idle_ready", 8'(req_ready), 8'd1);
    tick;
    req_valid = 1'b0;
    #1;
    chk("t6_idx4", 8'(idx), 8'd4);
    chk("t6_valid4", 8'(idx_valid), 8'd1);
    chk("t6_done4", 8'(done), 8'd1);
    tick; #1;
    chk("t6_end_valid", 8'(idx_valid), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/enc8_3_serial.md
Name: enc8_3_serial

Overview:
- Sequential counterpart to the team's 3:8 decoder: accepts an 8-bit request vector and emits the 3-bit index of every set bit, one per handshake, highest index first.
- Sits upstream of dec3_8: each emitted index can be fed straight into a decoder to regenerate the corresponding one-hot line.
- Uses valid/ready handshakes on both the input and output sides, with a global enable for stalling.

Parameters:
- N, 8, request vector width; the only supported value in this release.
- W, 3, index width, equal to clog2(N); fixed at 3.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  global enable; when 0, the block is frozen
- req  input  N  request vector
- req_valid  input  1  req is presented
- req_ready  output  1  block can accept a new vector
- idx  output  W  current index (registered)
- idx_valid  output  1  idx is valid
- idx_ready  input  1  consumer accepts idx
- done  output  1  one-cycle pulse when the last index of a vector is accepted
- zero_err  output  1  one-cycle pulse when an all-zero vector is accepted

Behaviour:
- State register: IDLE or EMIT. Internal pend[N-1:0] holds the bits not yet emitted.
- Reset (rst=1 at a clock edge, overrides en): state=IDLE, pend=0, idx=0, idx_valid=0, done=0, zero_err=0. req_ready is 1 in the cycle after reset.
- req_ready = en & (state==IDLE). This is combinational from state and en.
- idx_valid = (state==EMIT). It is registered via state.
- en=0: no state, pend, or idx update. idx_valid and idx stay stable. idx_ready and req_valid are ignored. done and zero_err are forced to 0.
- Priority encode function penc(v): returns the index of the highest set bit of v, or 0 when v=0.
- IDLE, input handshake (req_valid & req_ready):
  - req!=0: pend<=req, idx<=penc(req), state<=EMIT. idx_valid is high on the very next cycle, so latency is 1 cycle.
  - req==0: remain in IDLE, zero_err=1 for one cycle, nothing emitted.
- EMIT, output handshake (idx_valid & idx_ready & en):
  - nxt = pend & ~(1<<idx).
  - nxt!=0: pend<=nxt, idx<=penc(nxt), stay in EMIT. This gives back-to-back emission with no bubble.
  - nxt==0: pend<=0, state<=IDLE, done=1 for that one cycle (asserted combinationally in the handshake cycle). req_ready rises on the next cycle.
- EMIT without a handshake: idx and idx_valid hold (consumer back-pressure).
- Throughput: a vector with k set bits occupies exactly k output-handshake cycles, plus one IDLE cycle before the next vector is accepted.
- req is sampled only at the input handshake. Changes on req during EMIT have no effect.
- req_valid asserted during EMIT: it is not accepted, and the requester must hold it.
- Reset mid-EMIT: the remaining pend bits are discarded, no done pulse is issued, and idx_valid is 0 on the next cycle.
- Width rules: idx is exactly W bits. No arithmetic overflow is possible. All outputs are driven on every cycle, with no X.

Decomposition:
- Shared package enc_pkg holds:
  - constants N=8, W=3;
  - state typedef {IDLE, EMIT}.
- One combinational sub-module, pri_enc8_3 (input v[7:0], outputs y[2:0] and any). It implements penc and is instantiated twice: once on req, once on nxt.
- The state machine, pend register and handshake logic live in enc8_3_serial.

Test Plan:
1. Reset, then req=8'b1010_0100 with req_valid=1 and idx_ready held at 1 → idx sequence 7, 5, 2 on three consecutive cycles starting 1 cycle after acceptance; done pulses with idx=2; req_ready returns to 1 on the next cycle.
2. req=8'h00 accepted → zero_err pulses once, idx_valid stays 0, req_ready stays 1.
3. req=8'hFF with idx_ready toggling 1,0,1,0 → idx holds across the 0 cycles; the full sequence is 7,6,5,4,3,2,1,0; exactly 8 handshakes; one done pulse.
4. req=8'h81, then drop en for 3 cycles after the first handshake (idx=7) → idx stays 0-pending (idx=0, idx_valid=1) and is frozen; once en returns, idx=0 completes with done.
5. req=8'h3C, assert rst after the first emitted index (5) → next cycle idx_valid=0, idx=0, req_ready=1, no done pulse; a new req=8'h01 then yields idx=0.
6. req_valid held during EMIT with a different vector (8'h10) while 8'h06 is in flight → output is 2, 1, then 8'h10 is accepted and yields 4.
